// File: rtl/mem_access_unit_pkg.sv
// Shared encodings and decode helpers for the memory-access pipeline stage.
package mem_access_unit_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_LWU, MEM_LD,
    MEM_SB, MEM_SH, MEM_SW, MEM_SD,
    MEM_LL, MEM_SC
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mau_state_e;

  localparam logic        writeDisable = 1'b0;
  localparam logic [4:0]  NOPRegAddr   = 5'd0;
  localparam logic [63:0] zeroword     = 64'd0;

  // log2 of the access size in bytes
  function automatic logic [1:0] op_size(input mem_op_e op);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB:                     op_size = 2'd0;
      MEM_LH, MEM_LHU, MEM_SH:                     op_size = 2'd1;
      MEM_LW, MEM_LWU, MEM_SW, MEM_LL, MEM_SC:     op_size = 2'd2;
      default:                                     op_size = 2'd3;
    endcase
  endfunction

  function automatic logic op_is_load(input mem_op_e op);
    case (op)
      MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_LWU, MEM_LD, MEM_LL: op_is_load = 1'b1;
      default:                                                            op_is_load = 1'b0;
    endcase
  endfunction

  function automatic logic op_is_store(input mem_op_e op);
    case (op)
      MEM_SB, MEM_SH, MEM_SW, MEM_SD, MEM_SC: op_is_store = 1'b1;
      default:                                op_is_store = 1'b0;
    endcase
  endfunction

  function automatic logic op_is_signed(input mem_op_e op);
    case (op)
      MEM_LB, MEM_LH, MEM_LW, MEM_LL: op_is_signed = 1'b1;
      default:                        op_is_signed = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// mem_lane_align: little-endian lane handling; store replication and byte enables,
// load extract with sign/zero extension. Purely combinational.
module mem_lane_align
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  mem_op_e                     op_i,
  input  logic [$clog2(DATA_W/8)-1:0] lane_i,
  input  logic [DATA_W-1:0]           wdata_i,
  input  logic [DATA_W-1:0]           rdata_i,
  output logic [DATA_W/8-1:0]         be_o,
  output logic [DATA_W-1:0]           wdata_rep_o,
  output logic [DATA_W-1:0]           load_o
);

  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int SH_W   = $clog2(DATA_W);

  logic [LANE_W-1:0] mask;
  logic [DATA_W-1:0] shifted;
  logic [SH_W-1:0]   top_bit;
  logic              fill;

  always_comb begin
    mask = LANE_W'((32'd1 << op_size(op_i)) - 32'd1);
    // byte i of the bus carries source byte (i mod size); enabled when i lies in the addressed chunk
    for (int i = 0; i < NB; i++) begin
      be_o[i]             = ((LANE_W'(i) & ~mask) == (lane_i & ~mask));
      wdata_rep_o[i*8 +: 8] = wdata_i[{LANE_W'(i) & mask, 3'b000} +: 8];
    end
    shifted = rdata_i >> {lane_i, 3'b000};
    top_bit = SH_W'((32'd8 << op_size(op_i)) - 32'd1);
    fill    = op_is_signed(op_i) & shifted[top_bit];
    load_o  = shifted;
    for (int b = 0; b < DATA_W; b++) begin
      if (SH_W'(b) > top_bit) load_o[b] = fill;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: EX/MEM -> MEM/WB stage; non-memory ops pass through in 0 cycles, memory ops run
// IDLE/BUSY/DONE over a req/ack port with stall held until ack. `MEM_LLSC_EN adds the LL/SC llbit.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] w_addr_i,
  input  logic [DATA_W-1:0]     w_data_i,
  input  logic [3:0]            mem_op_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [DATA_W-1:0]     mem_wdata_i,
  input  logic                  flush_i,
  output logic                  we_o,
  output logic [REG_ADDR_W-1:0] w_addr_o,
  output logic [DATA_W-1:0]     w_data_o,
  output logic                  stall_req_o,
  output logic                  excp_align_o,
  output logic                  dm_req_o,
  output logic                  dm_we_o,
  output logic [ADDR_W-1:0]     dm_addr_o,
  output logic [DATA_W/8-1:0]   dm_be_o,
  output logic [DATA_W-1:0]     dm_wdata_o,
  input  logic [DATA_W-1:0]     dm_rdata_i,
  input  logic                  dm_ack_i
);

  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = $clog2(NB);

  mau_state_e        state;
  mem_op_e           op_raw, op_eff, op_q, lane_op;
  logic              kill, is_mem, misaligned, sc_fail, start;
  logic [2:0]        align_mask;
  logic [LANE_W-1:0] lane;
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] rdata_q, wdata_rep, load_ext;

  assign op_raw = mem_op_e'(mem_op_i);

  // 64-bit-only opcodes degrade to plain pass-through on a 32-bit datapath
  always_comb begin
    op_eff = op_raw;
    if (DATA_W == 32 && (op_raw == MEM_LWU || op_raw == MEM_LD || op_raw == MEM_SD))
      op_eff = MEM_NONE;
  end

  assign is_mem     = op_is_load(op_eff) | op_is_store(op_eff);
  assign align_mask = 3'((4'd1 << op_size(op_eff)) - 4'd1);
  assign misaligned = is_mem & (|(mem_addr_i[2:0] & align_mask));

`ifdef MEM_LLSC_EN
  logic llbit;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      llbit <= 1'b0;
    end else if (state == ST_BUSY && dm_ack_i) begin
      if (op_q == MEM_LL)      llbit <= 1'b1;
      else if (op_q == MEM_SC) llbit <= 1'b0;
    end
  end

  assign sc_fail = (op_eff == MEM_SC) && !llbit;
`else
  assign sc_fail = 1'b0;
`endif

  assign start = (state == ST_IDLE) & is_mem & ~misaligned & ~sc_fail & ~flush_i;

  // IDLE shapes the outgoing request; later states decode the captured response
  assign lane_op = (state == ST_IDLE) ? op_eff : op_q;
  assign lane    = (state == ST_IDLE) ? mem_addr_i[LANE_W-1:0] : dm_addr_o[LANE_W-1:0];

  mem_lane_align #(.DATA_W(DATA_W)) u_lane_align (
    .op_i        (lane_op),
    .lane_i      (lane),
    .wdata_i     (mem_wdata_i),
    .rdata_i     (rdata_q),
    .be_o        (be),
    .wdata_rep_o (wdata_rep),
    .load_o      (load_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      kill       <= 1'b0;
      op_q       <= MEM_NONE;
      rdata_q    <= '0;
      dm_req_o   <= 1'b0;
      dm_we_o    <= 1'b0;
      dm_addr_o  <= '0;
      dm_be_o    <= '0;
      dm_wdata_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_BUSY;
            kill       <= 1'b0;
            op_q       <= op_eff;
            dm_req_o   <= 1'b1;
            dm_we_o    <= op_is_store(op_eff);
            dm_addr_o  <= mem_addr_i;
            dm_be_o    <= be;
            dm_wdata_o <= wdata_rep;
          end
        end
        ST_BUSY: begin
          // a flush cannot abort the bus cycle; it only suppresses the write-back
          if (flush_i) kill <= 1'b1;
          if (dm_ack_i) begin
            state    <= ST_DONE;
            rdata_q  <= dm_rdata_i;
            dm_req_o <= 1'b0;
            dm_we_o  <= 1'b0;
            dm_be_o  <= '0;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          kill  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    we_o         = writeDisable;
    w_addr_o     = REG_ADDR_W'(NOPRegAddr);
    w_data_o     = DATA_W'(zeroword);
    stall_req_o  = 1'b0;
    excp_align_o = 1'b0;
    if (!rst) begin
      case (state)
        ST_IDLE: begin
          if (!is_mem) begin
            we_o     = we_i;
            w_addr_o = w_addr_i;
            w_data_o = w_data_i;
          end else if (misaligned) begin
            excp_align_o = 1'b1;
          end else if (sc_fail) begin
            we_o     = we_i & ~flush_i;
            w_addr_o = w_addr_i;
          end else begin
            stall_req_o = ~flush_i;
          end
        end
        ST_BUSY: stall_req_o = 1'b1;
        ST_DONE: begin
          we_o     = we_i & ~kill & ~flush_i;
          w_addr_o = w_addr_i;
          if (op_is_load(op_q))    w_data_o = load_ext;
          else if (op_q == MEM_SC) w_data_o = DATA_W'(1);
          else                     w_data_o = w_data_i;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (32-bit datapath) with a scripted req/ack memory responder.
module tb_mem_access_unit;

  localparam int DATA_W = 32, ADDR_W = 32, REG_ADDR_W = 5;

  localparam logic [3:0] OP_NONE = 4'd0,  OP_LB = 4'd1,  OP_LBU = 4'd2, OP_LH = 4'd3,
                         OP_LHU  = 4'd4,  OP_LW = 4'd5,  OP_LD  = 4'd7, OP_SB = 4'd8,
                         OP_SH   = 4'd9,  OP_LL = 4'd12, OP_SC  = 4'd13;

  logic                  clk = 1'b0;
  logic                  rst, we_i, flush_i, dm_ack_i;
  logic [REG_ADDR_W-1:0] w_addr_i, w_addr_o;
  logic [DATA_W-1:0]     w_data_i, w_data_o, mem_wdata_i, dm_wdata_o, dm_rdata_i;
  logic [3:0]            mem_op_i, dm_be_o;
  logic [ADDR_W-1:0]     mem_addr_i, dm_addr_o;
  logic                  we_o, stall_req_o, excp_align_o, dm_req_o, dm_we_o;

  int          checks = 0, errors = 0;
  int          stall_cnt, busy_cnt, hold_bad;
  logic        seen_req, timed_out, cap_we;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_ADDR_W(REG_ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .we_i(we_i), .w_addr_i(w_addr_i), .w_data_i(w_data_i),
    .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .flush_i(flush_i),
    .we_o(we_o), .w_addr_o(w_addr_o), .w_data_o(w_data_o),
    .stall_req_o(stall_req_o), .excp_align_o(excp_align_o),
    .dm_req_o(dm_req_o), .dm_we_o(dm_we_o), .dm_addr_o(dm_addr_o), .dm_be_o(dm_be_o),
    .dm_wdata_o(dm_wdata_o), .dm_rdata_i(dm_rdata_i), .dm_ack_i(dm_ack_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Applies an op at a negedge and plays memory: ack in BUSY cycle ack_after, flush in BUSY cycle flush_at.
  // Returns just after the negedge of the first cycle with neither stall nor request (DONE, or IDLE if none issued).
  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input int ack_after, input logic [31:0] rd, input int flush_at);
    mem_op_i = op; mem_addr_i = addr; mem_wdata_i = wd; dm_rdata_i = rd;
    stall_cnt = 0; busy_cnt = 0; hold_bad = 0; seen_req = 1'b0; timed_out = 1'b1;
    #1;
    for (int c = 0; c < 30; c++) begin
      if (stall_req_o) stall_cnt++;
      if (dm_req_o) begin
        if (!seen_req) begin
          cap_addr = dm_addr_o; cap_wdata = dm_wdata_o; cap_be = dm_be_o; cap_we = dm_we_o;
        end else if (dm_addr_o !== cap_addr || dm_wdata_o !== cap_wdata ||
                     dm_be_o !== cap_be || dm_we_o !== cap_we) begin
          hold_bad++;
        end
        seen_req = 1'b1;
        busy_cnt++;
        if (busy_cnt == ack_after) dm_ack_i = 1'b1;
        if (busy_cnt == flush_at)  flush_i  = 1'b1;
      end else if (!stall_req_o) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
      dm_ack_i = 1'b0;
      flush_i  = 1'b0;
      #1;
    end
    chk("txn_completes", {31'd0, timed_out}, 32'd0);
  endtask

  task automatic retire();
    mem_op_i = OP_NONE;
    flush_i  = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // reset with busy-looking inputs: outputs must still read zero
    rst = 1'b1; we_i = 1'b1; w_addr_i = 5'd7; w_data_i = 32'hA5A5; mem_op_i = OP_LW;
    mem_addr_i = 32'h10; mem_wdata_i = 32'h1; flush_i = 1'b0; dm_rdata_i = '0; dm_ack_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_we", {31'd0, we_o}, 32'd0);
    chk("rst_waddr", {27'd0, w_addr_o}, 32'd0);
    chk("rst_wdata", w_data_o, 32'd0);
    chk("rst_stall", {31'd0, stall_req_o}, 32'd0);
    chk("rst_excp", {31'd0, excp_align_o}, 32'd0);
    chk("rst_req", {31'd0, dm_req_o}, 32'd0);
    chk("rst_be", {28'd0, dm_be_o}, 32'd0);
    chk("rst_dmaddr", dm_addr_o, 32'd0);

    // pass-through
    rst = 1'b0; mem_op_i = OP_NONE; we_i = 1'b1; w_addr_i = 5'd3; w_data_i = 32'h1234;
    #1;
    chk("pass_we", {31'd0, we_o}, 32'd1);
    chk("pass_waddr", {27'd0, w_addr_o}, 32'd3);
    chk("pass_wdata", w_data_o, 32'h1234);
    chk("pass_stall", {31'd0, stall_req_o}, 32'd0);
    @(negedge clk);

    // LB sign extension, ack in second BUSY cycle
    w_addr_i = 5'd5; w_data_i = 32'h55;
    issue(OP_LB, 32'h1001, 32'h0, 2, 32'h0000_8000, 0);
    chk("lb_data", w_data_o, 32'hFFFF_FF80);
    chk("lb_we", {31'd0, we_o}, 32'd1);
    chk("lb_waddr", {27'd0, w_addr_o}, 32'd5);
    chk("lb_stall_cycles", stall_cnt, 32'd3);
    chk("lb_req_done", {31'd0, dm_req_o}, 32'd0);
    chk("lb_addr", cap_addr, 32'h1001);
    chk("lb_be", {28'd0, cap_be}, 32'h2);
    chk("lb_dmwe", {31'd0, cap_we}, 32'd0);
    chk("lb_hold", hold_bad, 32'd0);
    retire();

    issue(OP_LBU, 32'h1001, 32'h0, 2, 32'h0000_8000, 0);
    chk("lbu_data", w_data_o, 32'h80);
    chk("lbu_stall_cycles", stall_cnt, 32'd3);
    retire();

    // SH store: replication and byte enables; write-back passes EX value
    w_data_i = 32'h77;
    issue(OP_SH, 32'h2002, 32'h0000_ABCD, 1, 32'h0, 0);
    chk("sh_be", {28'd0, cap_be}, 32'hC);
    chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
    chk("sh_dmwe", {31'd0, cap_we}, 32'd1);
    chk("sh_we", {31'd0, we_o}, 32'd1);
    chk("sh_wb_data", w_data_o, 32'h77);
    chk("sh_stall_cycles", stall_cnt, 32'd2);
    retire();

    issue(OP_LH, 32'h1002, 32'h0, 1, 32'h8001_0000, 0);
    chk("lh_data", w_data_o, 32'hFFFF_8001);
    retire();
    issue(OP_LHU, 32'h1000, 32'h0, 1, 32'h0000_F00F, 0);
    chk("lhu_data", w_data_o, 32'h0000_F00F);
    retire();
    issue(OP_LW, 32'h1004, 32'h0, 1, 32'hCAFE_BABE, 0);
    chk("lw_data", w_data_o, 32'hCAFE_BABE);
    chk("lw_be", {28'd0, cap_be}, 32'hF);
    retire();
    issue(OP_SB, 32'h2003, 32'h0000_005A, 1, 32'h0, 0);
    chk("sb_be", {28'd0, cap_be}, 32'h8);
    chk("sb_wdata", cap_wdata, 32'h5A5A_5A5A);
    retire();

    // misaligned accesses
    issue(OP_LW, 32'h3001, 32'h0, 0, 32'h0, 0);
    chk("mis_lw_excp", {31'd0, excp_align_o}, 32'd1);
    chk("mis_lw_we", {31'd0, we_o}, 32'd0);
    chk("mis_lw_stall", stall_cnt, 32'd0);
    chk("mis_lw_req", {31'd0, seen_req}, 32'd0);
    @(negedge clk); #1;
    chk("mis_lw_req_later", {31'd0, dm_req_o}, 32'd0);
    retire();
    issue(OP_LH, 32'h3003, 32'h0, 0, 32'h0, 0);
    chk("mis_lh_excp", {31'd0, excp_align_o}, 32'd1);
    retire();

    // LD is not legal on a 32-bit datapath: behaves as NONE
    w_data_i = 32'h99;
    issue(OP_LD, 32'h3001, 32'h0, 0, 32'h0, 0);
    chk("ld32_excp", {31'd0, excp_align_o}, 32'd0);
    chk("ld32_wdata", w_data_o, 32'h99);
    chk("ld32_req", {31'd0, seen_req}, 32'd0);
    retire();

    // flush in BUSY: request held to ack, write-back killed
    issue(OP_LW, 32'h1008, 32'h0, 3, 32'h11, 1);
    chk("flb_we", {31'd0, we_o}, 32'd0);
    chk("flb_busy_cycles", busy_cnt, 32'd3);
    chk("flb_hold", hold_bad, 32'd0);
    chk("flb_stall_cycles", stall_cnt, 32'd4);
    retire();

    // flush in IDLE: no request
    mem_op_i = OP_LW; mem_addr_i = 32'h100C; flush_i = 1'b1;
    #1;
    chk("fli_stall", {31'd0, stall_req_o}, 32'd0);
    @(negedge clk); #1;
    chk("fli_req", {31'd0, dm_req_o}, 32'd0);
    retire();

    // reset mid-BUSY
    mem_op_i = OP_LW; mem_addr_i = 32'h1010;
    @(negedge clk); #1;
    chk("rstb_req_busy", {31'd0, dm_req_o}, 32'd1);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("rstb_req_after", {31'd0, dm_req_o}, 32'd0);
    chk("rstb_stall_after", {31'd0, stall_req_o}, 32'd0);
    rst = 1'b0; mem_op_i = OP_NONE; dm_ack_i = 1'b1;
    @(negedge clk); #1;
    chk("stray_ack_req", {31'd0, dm_req_o}, 32'd0);
    chk("stray_ack_stall", {31'd0, stall_req_o}, 32'd0);
    dm_ack_i = 1'b0;
    @(negedge clk);

    // LL / SC
    w_data_i = 32'h55;
    issue(OP_LL, 32'h40, 32'h0, 1, 32'hFFFF_FFFE, 0);
    chk("ll_data", w_data_o, 32'hFFFF_FFFE);
    retire();
    issue(OP_SC, 32'h40, 32'h1234, 1, 32'h0, 0);
    chk("sc1_req", {31'd0, seen_req}, 32'd1);
    chk("sc1_wdata", cap_wdata, 32'h1234);
    chk("sc1_result", w_data_o, 32'd1);
    retire();
    issue(OP_SC, 32'h40, 32'h5678, 1, 32'h0, 0);
`ifdef MEM_LLSC_EN
    chk("sc2_req", {31'd0, seen_req}, 32'd0);
    chk("sc2_stall", stall_cnt, 32'd0);
    chk("sc2_result", w_data_o, 32'd0);
    chk("sc2_we", {31'd0, we_o}, 32'd1);
    retire();
    issue(OP_LL, 32'h40, 32'h0, 1, 32'h1, 0);
    retire();
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    issue(OP_SC, 32'h40, 32'h9, 1, 32'h0, 0);
    chk("sc_after_flush_req", {31'd0, seen_req}, 32'd0);
`else
    chk("sc2_req", {31'd0, seen_req}, 32'd1);
    chk("sc2_result", w_data_o, 32'd1);
`endif
    retire();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of run, required finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
